// File: rtl/uart_tx_packet_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART packet send path: arbiter state encoding,
// default packet width and the largest legal byte count. The FIFO instance
// uses the same constants so both sides agree on the packet format.
// ---------------------------------------------------------------------------
package uart_pkt_pkg;

    localparam int PKT_DATA_WIDTH = 192;
    localparam int PKT_MAX_BYTES  = PKT_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PUSH  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Index width for an n-entry requester vector; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pick
// Combinational round-robin picker. Searches the request vector starting one
// position after the pointer (wrapping) and returns the first set index.
// Ports:
//   i_req        request vector
//   i_rr_ptr     index of the previous grantee (lowest priority)
//   o_grant_idx  chosen requester (0 when none)
//   o_valid      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter_pick
    import uart_pkt_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_rr_ptr,
    output logic [IDX_WIDTH-1:0] o_grant_idx,
    output logic                 o_valid
);

    localparam int SUM_W = IDX_WIDTH + 1;

    // w_cand[k] is the requester examined at search step k (priority order).
    logic [IDX_WIDTH-1:0] w_cand [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] w_sum;
            assign w_sum = {1'b0, i_rr_ptr} + SUM_W'(gi + 1);
            // One conditional subtract suffices: ptr + k < 2*NUM_REQ.
            assign w_cand[gi] = IDX_WIDTH'((w_sum >= SUM_W'(NUM_REQ)) ?
                                           (w_sum - SUM_W'(NUM_REQ)) : w_sum);
        end
    endgenerate

    always_comb begin
        o_valid     = 1'b0;
        o_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && i_req[w_cand[k]]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_packet_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_packet_arbiter
// Shares the single packet-send port of the UART packet FIFO among NUM_REQ
// requesters. Round-robin grant, latch of the winner's packet, byte-count
// validation, one FIFO write strobe when space is available, then a one-cycle
// ack (written) or err (illegal count) back to the winner.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_req                  per-requester request level
//   i_req_data             packed packets, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_req_amount           packed byte counts
//   o_req_ack / o_req_err  one-cycle completion pulses to the grantee
//   o_fifo_snd_clk         one-cycle FIFO write strobe
//   o_fifo_data/_amount    latched packet and byte count toward the FIFO
//   i_fifo_available       FIFO not full
//   o_busy                 arbiter is handling a packet
//   o_grant_idx            current or last grantee
// ---------------------------------------------------------------------------
module uart_tx_packet_arbiter
    import uart_pkt_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = PKT_DATA_WIDTH,
    parameter int MAX_BYTES    = DATA_WIDTH / 8,
    parameter int AMOUNT_WIDTH = $clog2(DATA_WIDTH / 8),
    parameter int IDX_WIDTH    = idx_width(NUM_REQ)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ*AMOUNT_WIDTH-1:0] i_req_amount,
    output logic [NUM_REQ-1:0]              o_req_ack,
    output logic [NUM_REQ-1:0]              o_req_err,
    output logic                            o_fifo_snd_clk,
    output logic [DATA_WIDTH-1:0]           o_fifo_data,
    output logic [AMOUNT_WIDTH-1:0]         o_fifo_amount,
    input  logic                            i_fifo_available,
    output logic                            o_busy,
    output logic [IDX_WIDTH-1:0]            o_grant_idx
);

    // Unpacked views of the flattened request buses.
    logic [DATA_WIDTH-1:0]   w_req_data   [NUM_REQ];
    logic [AMOUNT_WIDTH-1:0] w_req_amount [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi]   = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_req_amount[gi] = i_req_amount[gi*AMOUNT_WIDTH +: AMOUNT_WIDTH];
        end
    endgenerate

    arb_state_e              r_state,     w_state_next;
    logic [IDX_WIDTH-1:0]    r_rr_ptr,    w_rr_ptr_next;
    logic [IDX_WIDTH-1:0]    r_grant_idx, w_grant_idx_next;
    logic [DATA_WIDTH-1:0]   r_data,      w_data_next;
    logic [AMOUNT_WIDTH-1:0] r_amount,    w_amount_next;
    logic [NUM_REQ-1:0]      r_ack,       w_ack_next;
    logic [NUM_REQ-1:0]      r_err,       w_err_next;
    logic                    r_snd_clk,   w_snd_clk_next;

    logic [IDX_WIDTH-1:0]    w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_amount_bad;

    rr_arbiter_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .i_req       (i_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_idx (w_pick_idx),
        .o_valid     (w_pick_valid)
    );

    // A zero count would hang the FIFO fetcher, so it is rejected too.
    assign w_amount_bad = (r_amount == '0) ||
                          (r_amount > AMOUNT_WIDTH'(MAX_BYTES));

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_grant_idx_next = r_grant_idx;
        w_data_next      = r_data;
        w_amount_next    = r_amount;
        w_ack_next       = '0;
        w_err_next       = '0;
        w_snd_clk_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_idx_next = w_pick_idx;
                    w_data_next      = w_req_data[w_pick_idx];
                    w_amount_next    = w_req_amount[w_pick_idx];
                    w_state_next     = CHECK;
                end
            end
            CHECK: begin
                if (w_amount_bad) begin
                    w_err_next[r_grant_idx] = 1'b1;
                    w_state_next            = DONE;
                end else begin
                    w_state_next = PUSH;
                end
            end
            PUSH: begin
                if (i_fifo_available) begin
                    w_snd_clk_next          = 1'b1;
                    w_ack_next[r_grant_idx] = 1'b1;
                    w_state_next            = DONE;
                end
            end
            DONE: begin
                // req is ignored here: the grantee may still be dropping it.
                w_rr_ptr_next = r_grant_idx;
                w_state_next  = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= IDX_WIDTH'(NUM_REQ - 1);
            r_grant_idx <= '0;
            r_data      <= '0;
            r_amount    <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_snd_clk   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_grant_idx <= w_grant_idx_next;
            r_data      <= w_data_next;
            r_amount    <= w_amount_next;
            r_ack       <= w_ack_next;
            r_err       <= w_err_next;
            r_snd_clk   <= w_snd_clk_next;
        end
    end

    assign o_req_ack      = r_ack;
    assign o_req_err      = r_err;
    assign o_fifo_snd_clk = r_snd_clk;
    assign o_fifo_data    = r_data;
    assign o_fifo_amount  = r_amount;
    assign o_busy         = (r_state != IDLE);
    assign o_grant_idx    = r_grant_idx;

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_packet_arbiter
// Directed bench for the two-requester configuration of the UART packet
// arbiter: reset, single packet latency, contention, illegal counts,
// backpressure, reset while stalled and a round-robin soak.
// ---------------------------------------------------------------------------
module tb_uart_tx_packet_arbiter;

    localparam int NR = 2;
    localparam int DW = 192;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR*AW-1:0] req_amount;
    logic            avail;
    logic [NR-1:0]   ack, err;
    logic            snd;
    logic [DW-1:0]   fdata;
    logic [AW-1:0]   famount;
    logic            busy;
    logic [0:0]      gidx;

    always #5 clk = ~clk;

    uart_tx_packet_arbiter #(
        .NUM_REQ (NR),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req            (req),
        .i_req_data       (req_data),
        .i_req_amount     (req_amount),
        .o_req_ack        (ack),
        .o_req_err        (err),
        .o_fifo_snd_clk   (snd),
        .o_fifo_data      (fdata),
        .o_fifo_amount    (famount),
        .i_fifo_available (avail),
        .o_busy           (busy),
        .o_grant_idx      (gidx)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] d0, d1, d2;

    // Values captured by wait_pulse on the first cycle any pulse is seen.
    int            p_cycles;
    logic [NR-1:0] p_ack, p_err;
    logic          p_snd;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_amt;
    logic [0:0]    p_grant;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to budget cycles for ack/err/strobe; p_cycles = -1 on timeout.
    task automatic wait_pulse(input int budget);
        p_cycles = -1;
        p_ack = '0; p_err = '0; p_snd = 1'b0; p_data = '0; p_amt = '0; p_grant = '0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if ((ack != '0) || (err != '0) || snd) begin
                p_cycles = c;
                p_ack = ack; p_err = err; p_snd = snd;
                p_data = fdata; p_amt = famount; p_grant = gidx;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; avail = 1'b0; req_data = '0; req_amount = '0;
        tick();
        tick();
        vectors++; if (ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b want 00", ack); end
        vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b want 00", err); end
        vectors++; if (snd !== 1'b0) begin miscompares++; $display("FAIL reset_snd: got %b want 0", snd); end
        vectors++; if (fdata !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", fdata); end
        vectors++; if (famount !== '0) begin miscompares++; $display("FAIL reset_amount: got %0d want 0", famount); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (gidx !== 1'b0) begin miscompares++; $display("FAIL reset_grant: got %0d want 0", gidx); end
        rst_n = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_packet();
        logic [DW-1:0] d;
        d = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h000000A1B2C3D4E5};
        avail = 1'b1;
        req_data[0 +: DW] = d;
        req_amount[0 +: AW] = 5'd5;
        req = 2'b01;
        tick();
        vectors++; if (busy !== 1'b1 || snd !== 1'b0 || gidx !== 1'b0) begin miscompares++;
            $display("FAIL single_c1: got busy=%b snd=%b grant=%0d want busy=1 snd=0 grant=0", busy, snd, gidx); end
        tick();
        vectors++; if (snd !== 1'b0 || ack !== 2'b00) begin miscompares++;
            $display("FAIL single_c2: got snd=%b ack=%b want snd=0 ack=00", snd, ack); end
        tick();
        vectors++; if (snd !== 1'b1 || ack !== 2'b01 || err !== 2'b00) begin miscompares++;
            $display("FAIL single_c3: got snd=%b ack=%b err=%b want snd=1 ack=01 err=00", snd, ack, err); end
        vectors++; if (famount !== 5'd5 || fdata !== d) begin miscompares++;
            $display("FAIL single_payload: got amt=%0d data=%h want amt=5 data=%h", famount, fdata, d); end
        req = 2'b00;
        tick();
        vectors++; if (snd !== 1'b0 || ack !== 2'b00 || busy !== 1'b0) begin miscompares++;
            $display("FAIL single_c4: got snd=%b ack=%b busy=%b want 0 00 0", snd, ack, busy); end
        vectors++; if (fdata !== d) begin miscompares++;
            $display("FAIL single_hold: got %h want %h", fdata, d); end
    endtask

    task automatic test_contention();
        do_reset();
        avail = 1'b1;
        req_data[0 +: DW]  = d0;  req_amount[0 +: AW]  = 5'd24;
        req_data[DW +: DW] = d1;  req_amount[AW +: AW] = 5'd24;
        req = 2'b11;
        wait_pulse(20);
        vectors++; if (p_cycles !== 3 || p_ack !== 2'b01 || p_grant !== 1'b0 || p_data !== d0) begin miscompares++;
            $display("FAIL contend_first: got cyc=%0d ack=%b grant=%0d data=%h want 3 01 0 %h", p_cycles, p_ack, p_grant, p_data, d0); end
        req[0] = 1'b0;
        wait_pulse(20);
        vectors++; if (p_cycles !== 4 || p_ack !== 2'b10 || p_grant !== 1'b1 || p_data !== d1 || p_amt !== 5'd24) begin miscompares++;
            $display("FAIL contend_second: got cyc=%0d ack=%b grant=%0d amt=%0d data=%h want 4 10 1 24 %h", p_cycles, p_ack, p_grant, p_amt, p_data, d1); end
        req = 2'b01;
        wait_pulse(20);
        vectors++; if (p_cycles !== 4 || p_ack !== 2'b01 || p_grant !== 1'b0) begin miscompares++;
            $display("FAIL contend_rerequest: got cyc=%0d ack=%b grant=%0d want 4 01 0", p_cycles, p_ack, p_grant); end
        req = 2'b00;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL contend_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_illegal_count();
        logic [AW-1:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd25;
        avail = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_data[DW +: DW] = d1;
            req_amount[AW +: AW] = bad[i];
            req = 2'b10;
            wait_pulse(20);
            vectors++; if (p_cycles !== 2 || p_err !== 2'b10 || p_ack !== 2'b00 || p_snd !== 1'b0 || p_grant !== 1'b1) begin miscompares++;
                $display("FAIL illegal_amt%0d: got cyc=%0d err=%b ack=%b snd=%b grant=%0d want 2 10 00 0 1", bad[i], p_cycles, p_err, p_ack, p_snd, p_grant); end
            req = 2'b00;
            tick();
            vectors++; if (snd !== 1'b0 || err !== 2'b00 || busy !== 1'b0) begin miscompares++;
                $display("FAIL illegal_after%0d: got snd=%b err=%b busy=%b want 0 00 0", bad[i], snd, err, busy); end
        end
    endtask

    task automatic test_backpressure();
        avail = 1'b0;
        req_data[0 +: DW] = d2;
        req_amount[0 +: AW] = 5'd1;
        req = 2'b01;
        tick();
        tick();
        req_data[0 +: DW] = ~d2;   // must not disturb the latched packet
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++; if (snd !== 1'b0 || busy !== 1'b1 || fdata !== d2 || ack !== 2'b00) begin miscompares++;
                $display("FAIL stall_c%0d: got snd=%b busy=%b ack=%b data=%h want 0 1 00 %h", c, snd, busy, ack, fdata, d2); end
        end
        avail = 1'b1;
        tick();
        vectors++; if (snd !== 1'b1 || ack !== 2'b01 || fdata !== d2 || famount !== 5'd1) begin miscompares++;
            $display("FAIL stall_release: got snd=%b ack=%b amt=%0d data=%h want 1 01 1 %h", snd, ack, famount, fdata, d2); end
        req = 2'b00;
        tick();
        vectors++; if (snd !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL stall_done: got snd=%b busy=%b want 0 0", snd, busy); end
    endtask

    task automatic test_reset_in_push();
        avail = 1'b0;
        req_data[0 +: DW] = d0;
        req_amount[0 +: AW] = 5'd3;
        req = 2'b01;
        repeat (4) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstpush_stalled: got busy=%b want 1", busy); end
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        vectors++; if (busy !== 1'b0 || fdata !== '0 || famount !== '0 || gidx !== 1'b0 || ack !== 2'b00 || snd !== 1'b0) begin miscompares++;
            $display("FAIL rstpush_async: got busy=%b amt=%0d grant=%0d ack=%b snd=%b data=%h want all 0", busy, famount, gidx, ack, snd, fdata); end
        avail = 1'b1;
        tick();
        tick();
        vectors++; if (ack !== 2'b00 || snd !== 1'b0) begin miscompares++;
            $display("FAIL rstpush_noack: got ack=%b snd=%b want 00 0", ack, snd); end
        rst_n = 1'b1;
        req_data[DW +: DW] = d1;
        req_amount[AW +: AW] = 5'd7;
        req = 2'b10;
        wait_pulse(20);
        vectors++; if (p_cycles !== 3 || p_ack !== 2'b10 || p_grant !== 1'b1 || p_amt !== 5'd7 || p_data !== d1) begin miscompares++;
            $display("FAIL rstpush_regrant: got cyc=%0d ack=%b grant=%0d amt=%0d want 3 10 1 7", p_cycles, p_ack, p_grant, p_amt); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_fairness();
        int cnt0, cnt1, exp_idx, exp_cyc;
        logic [NR-1:0] exp_ack;
        logic [DW-1:0] exp_data;
        cnt0 = 0; cnt1 = 0;
        do_reset();
        avail = 1'b1;
        req_data[0 +: DW]  = d0;  req_amount[0 +: AW]  = 5'd24;
        req_data[DW +: DW] = d1;  req_amount[AW +: AW] = 5'd24;
        req = 2'b11;
        for (int k = 0; k < 100; k++) begin
            wait_pulse(20);
            exp_idx  = k % 2;
            exp_ack  = (exp_idx == 0) ? 2'b01 : 2'b10;
            exp_data = (exp_idx == 0) ? d0 : d1;
            exp_cyc  = (k == 0) ? 3 : 4;
            if (p_ack == 2'b01) cnt0++;
            if (p_ack == 2'b10) cnt1++;
            vectors++; if (p_cycles !== exp_cyc || p_ack !== exp_ack || p_data !== exp_data) begin miscompares++;
                $display("FAIL soak_pkt%0d: got cyc=%0d ack=%b want cyc=%0d ack=%b", k, p_cycles, p_ack, exp_cyc, exp_ack); end
        end
        req = 2'b00;
        tick();
        vectors++; if (cnt0 !== 50 || cnt1 !== 50) begin miscompares++;
            $display("FAIL soak_counts: got %0d/%0d want 50/50", cnt0, cnt1); end
    endtask

    initial begin
        d0 = {96'h111122223333444455556666, 96'h777788889999AAAABBBBCCCC};
        d1 = {96'hCAFEF00DCAFEF00DCAFEF00D, 96'h0BADBEEF0BADBEEF0BADBEEF};
        d2 = {96'h5A5A5A5A5A5A5A5A5A5A5A5A, 96'hA5A5A5A5A5A5A5A5A5A5A5A5};
        test_reset();
        test_single_packet();
        test_contention();
        test_illegal_count();
        test_backpressure();
        test_reset_in_push();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
